// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and decode helpers for the load/store unit.
// LSU_MISALIGNED_SPLIT_EN adds the second bus phase (ST_REQ2) for misaligned accesses.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
`ifdef LSU_MISALIGNED_SPLIT_EN
    ST_REQ2 = 2'd2,
`endif
    ST_DONE = 2'd3
  } lsu_state_e;

  // Unsigned loads have no store counterpart.
  function automatic logic size_legal(input logic [2:0] f3, input logic is_store);
    case (f3)
      F3_B, F3_H, F3_W: size_legal = 1'b1;
      F3_BU, F3_HU:     size_legal = !is_store;
      default:          size_legal = 1'b0;
    endcase
  endfunction

  function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_H, F3_HU: is_aligned = !off[0];
      F3_W:        is_aligned = (off == 2'b00);
      default:     is_aligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables and data shift, load extract and sign/zero extend.
// hi selects the upper word of a two-word (split) access.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  off,
  input  logic        is_store,
  input  logic        hi,
  input  logic [31:0] wdata,
  input  logic [63:0] rword,
  output logic [3:0]  be_c,
  output logic [31:0] wdata_c,
  output logic [31:0] rdata_c
);

  logic [3:0]  base;
  logic [7:0]  be_full;
  logic [63:0] wdata_full;
  logic [31:0] shifted;

  always_comb begin
    case (size)
      F3_B, F3_BU: base = BE_B;
      F3_H, F3_HU: base = BE_H;
      default:     base = BE_W;
    endcase
    be_full    = is_store ? (8'(base) << off) : 8'hFF;
    wdata_full = 64'(wdata) << {off, 3'b000};
    be_c       = hi ? be_full[7:4] : be_full[3:0];
    wdata_c    = hi ? wdata_full[63:32] : wdata_full[31:0];
    shifted    = 32'(rword >> {off, 3'b000});
    case (size)
      F3_B:    rdata_c = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   rdata_c = {24'h0, shifted[7:0]};
      F3_H:    rdata_c = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   rdata_c = {16'h0, shifted[15:0]};
      default: rdata_c = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: req/ack bus master with stall, timeout and error reporting.
// Define LSU_MISALIGNED_SPLIT_EN to split misaligned half/word accesses into two bus phases.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lsu_start,
  input  logic              mem_rw,
  input  logic [2:0]        word_size_sel,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [31:0]       lsu_wdata,
  output logic              lsu_stall,
  output logic              lsu_done,
  output logic [31:0]       lsu_rdata,
  output logic              lsu_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
`ifdef LSU_MISALIGNED_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  lsu_state_e        state_q, state_d;
  logic              rw_q, rw_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wd_q, wd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              done_q, done_d, err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              req_q, req_d, we_q, we_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       mwdata_q, mwdata_d;
`ifdef LSU_MISALIGNED_SPLIT_EN
  logic              split_q, split_d;
  logic [31:0]       frag_q, frag_d;
`endif

  // Lane steering sees the live request in IDLE and the latched one afterwards.
  logic              sel_rw, hi_c;
  logic [2:0]        sel_f3;
  logic [ADDR_W-1:0] sel_addr, word_addr;
  logic [31:0]       sel_wd;
  logic [63:0]       rword;
  logic [3:0]        be_c;
  logic [31:0]       wdata_c, rdata_c;

  always_comb begin
    sel_rw    = (state_q == ST_IDLE) ? mem_rw        : rw_q;
    sel_f3    = (state_q == ST_IDLE) ? word_size_sel : f3_q;
    sel_addr  = (state_q == ST_IDLE) ? lsu_addr      : addr_q;
    sel_wd    = (state_q == ST_IDLE) ? lsu_wdata     : wd_q;
    word_addr = {sel_addr[ADDR_W-1:2], 2'b00};
`ifdef LSU_MISALIGNED_SPLIT_EN
    hi_c  = (state_q == ST_REQ);
    rword = (state_q == ST_REQ2) ? {mem_rdata, frag_q} : {32'h0, mem_rdata};
`else
    hi_c  = 1'b0;
    rword = {32'h0, mem_rdata};
`endif
  end

  lsu_align u_align (
    .size     (sel_f3),
    .off      (sel_addr[1:0]),
    .is_store (sel_rw),
    .hi       (hi_c),
    .wdata    (sel_wd),
    .rword    (rword),
    .be_c     (be_c),
    .wdata_c  (wdata_c),
    .rdata_c  (rdata_c)
  );

  always_comb begin
    state_d  = state_q;
    rw_d     = rw_q;
    f3_d     = f3_q;
    addr_d   = addr_q;
    wd_d     = wd_q;
    cnt_d    = cnt_q;
    cnt_inc  = cnt_q + CNT_W'(1);
    done_d   = 1'b0;
    err_d    = 1'b0;
    rdata_d  = '0;
    req_d    = 1'b0;
    we_d     = 1'b0;
    maddr_d  = '0;
    be_d     = '0;
    mwdata_d = '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
    split_d  = split_q;
    frag_d   = frag_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (lsu_start) begin
          rw_d   = mem_rw;
          f3_d   = word_size_sel;
          addr_d = lsu_addr;
          wd_d   = lsu_wdata;
          cnt_d  = '0;
          if (!size_legal(word_size_sel, mem_rw) ||
              (!SPLIT_EN && !is_aligned(word_size_sel, lsu_addr[1:0]))) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d  = ST_REQ;
            req_d    = 1'b1;
            we_d     = mem_rw;
            maddr_d  = word_addr;
            be_d     = be_c;
            mwdata_d = wdata_c;
`ifdef LSU_MISALIGNED_SPLIT_EN
            split_d  = !is_aligned(word_size_sel, lsu_addr[1:0]);
`endif
          end
        end
      end
`ifdef LSU_MISALIGNED_SPLIT_EN
      ST_REQ, ST_REQ2: begin
`else
      ST_REQ: begin
`endif
        if (mem_ack) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
          if (state_q == ST_REQ && split_q) begin
            state_d  = ST_REQ2;
            frag_d   = mem_rdata;
            cnt_d    = '0;
            req_d    = 1'b1;
            we_d     = we_q;
            maddr_d  = maddr_q + ADDR_W'(4);
            be_d     = be_c;
            mwdata_d = wdata_c;
          end else
`endif
          begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            rdata_d = rw_q ? 32'h0 : rdata_c;
          end
        end else if (TIMEOUT_CYC != 0 && cnt_inc == CNT_W'(TIMEOUT_CYC)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d    = cnt_inc;
          req_d    = req_q;
          we_d     = we_q;
          maddr_d  = maddr_q;
          be_d     = be_q;
          mwdata_d = mwdata_q;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rw_q     <= 1'b0;
      f3_q     <= '0;
      addr_q   <= '0;
      wd_q     <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      maddr_q  <= '0;
      be_q     <= '0;
      mwdata_q <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
      split_q  <= 1'b0;
      frag_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rw_q     <= rw_d;
      f3_q     <= f3_d;
      addr_q   <= addr_d;
      wd_q     <= wd_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      req_q    <= req_d;
      we_q     <= we_d;
      maddr_q  <= maddr_d;
      be_q     <= be_d;
      mwdata_q <= mwdata_d;
`ifdef LSU_MISALIGNED_SPLIT_EN
      split_q  <= split_d;
      frag_q   <= frag_d;
`endif
    end
  end

  assign lsu_stall = (state_q == ST_IDLE && lsu_start) || (state_q == ST_REQ)
`ifdef LSU_MISALIGNED_SPLIT_EN
                     || (state_q == ST_REQ2)
`endif
                     ;
  assign lsu_done  = done_q;
  assign lsu_err   = err_q;
  assign lsu_rdata = rdata_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = maddr_q;
  assign mem_be    = be_q;
  assign mem_wdata = mwdata_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Data-memory access stage directly downstream of the instruction decoder.
- Consumes the decoder's MemRW and WordSizeSel (funct3), the ALU-computed address and rs2 write data.
- Drives a req/ack word-wide data-memory bus and returns sign- or zero-extended load data to the WB mux.
- Holds the core with a stall signal while an access is in flight; flags misaligned, illegal-size and timed-out accesses.

Parameters:
- TIMEOUT_CYC, 255: maximum cycles mem_req may stay high without mem_ack before the access is aborted. 0 disables the timeout.
- ADDR_W, 32: byte address width.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- lsu_start  in  1  access request from the core; sampled only in IDLE
- mem_rw  in  1  0 = load, 1 = store (decoder MemRW)
- word_size_sel  in  3  funct3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- lsu_addr  in  ADDR_W  byte address from the ALU
- lsu_wdata  in  32  store data (rs2)
- lsu_stall  out  1  hold PC and pipeline while asserted
- lsu_done  out  1  one-cycle pulse; the access is complete
- lsu_rdata  out  32  extended load data; valid when lsu_done=1
- lsu_err  out  1  valid with lsu_done: misaligned, illegal size, or timeout
- mem_req  out  1  bus request
- mem_we  out  1  bus write enable
- mem_addr  out  ADDR_W  word-aligned address (bits [1:0] = 0)
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-shifted store data
- mem_ack  in  1  bus acknowledge; completes the transfer in the same cycle
- mem_rdata  in  32  read word; valid in the mem_ack cycle

Behaviour:
- Reset: state=IDLE. All outputs are 0, including mem_req, mem_be and lsu_rdata. The timeout counter is 0.
- States: IDLE, REQ, REQ2 (split build only), DONE.
- IDLE:
  - lsu_start=1 latches mem_rw, word_size_sel, lsu_addr and lsu_wdata.
  - Legal and aligned: next state REQ.
  - Illegal funct3 (011, 110, 111; stores also 100, 101) or misaligned: next state DONE with err=1 and no bus activity.
- Alignment rules:
  - Half-word requires addr[0]=0.
  - Word requires addr[1:0]=0.
  - Byte accesses are always aligned.
- lsu_stall = (IDLE & lsu_start) | REQ | REQ2. It is combinational and deasserts in the DONE cycle.
- REQ:
  - mem_req=1. mem_addr, mem_we, mem_be and mem_wdata are held stable until mem_ack.
  - mem_ack=1 moves to DONE and captures the extracted load data.
- Store lanes:
  - off = addr[1:0].
  - mem_be: SB = 0001<<off, SH = 0011<<off, SW = 1111.
  - mem_wdata = lsu_wdata<<(8*off).
- Load data:
  - Extract (mem_rdata>>(8*off)).
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
  - mem_be = 1111 for all loads.
  - Stores return lsu_rdata=0.
- Timeout: the counter increments each REQ cycle without ack. When it reaches TIMEOUT_CYC:
  - mem_req drops.
  - Next state DONE with err=1 and rdata=0.
  - A late mem_ack is ignored.
- DONE: lsu_done=1 for exactly one cycle, then IDLE. lsu_start is ignored in DONE; a new request is accepted only from IDLE in the following cycle.
- Reset asserted mid-access: mem_req drops in the next cycle, the access is abandoned and no done pulse is produced.
- mem_ack while mem_req=0 is ignored.

Optional Feature:
- Macro: LSU_MISALIGNED_SPLIT_EN.
- Defined: a misaligned half-word or word is split into two bus accesses, REQ then REQ2.
  - First access: address addr&~3, upper byte enables.
  - Second access: address (addr&~3)+4, wrapping modulo 2^ADDR_W, lower byte enables.
  - The two read fragments are merged, then extended.
  - err is set only for an illegal size or a timeout in either phase.
- Undefined: REQ2 is not present and misaligned accesses report err as above.

Decomposition:
- Package lsu_pkg:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State enum typedef.
  - Byte-enable base constants.
- Sub-module lsu_align: combinational lane shifter, byte-enable generator and sign/zero extender, instantiated once in the FSM top.

Test Plan:
1. SW 0xDEADBEEF at 0x100, ack after 3 cycles -> mem_addr=0x100, be=1111, wdata=0xDEADBEEF; stall for 4 cycles; done=1, err=0.
2. LB at 0x203, mem_rdata=0x80FF_FFFF, ack at once -> rdata=0xFFFFFF80; LBU at the same address -> 0x00000080.
3. LH at 0x202, mem_rdata=0x7FFF_0000 -> be=1111, rdata=0x00007FFF; SH 0x1234 at 0x202 -> be=1100, wdata=0x12340000.
4. LW at 0x101, split build off -> no mem_req, done the next cycle with err=1. Split build on, words 0xAABBCCDD at 0x100 and 0x11223344 at 0x104 -> rdata=0x44AABBCC.
5. TIMEOUT_CYC=4, no ack -> mem_req high for 4 cycles, then done with err=1 and rdata=0; an ack one cycle later is ignored.
6. rst asserted in the second REQ cycle -> mem_req=0 and all outputs 0 next cycle, no done pulse; funct3=011 -> err with no bus access.
